// File: rtl/pipe_sb_pkg.sv
// rtl/pipe_sb_pkg.sv - shared defaults and latency saturation helper for the pipe scoreboard
package pipe_sb_pkg;

  localparam int REG_CNT = 32;
  localparam int REG_AW  = 5;
  localparam int MAX_LAT = 4;
  localparam int LAT_W   = 3;

  function automatic int unsigned lat_sat(input int unsigned lat, input int unsigned max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - per-register result countdown: load, decrement, clear, busy
module sb_entry #(
  parameter int LAT_W = pipe_sb_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             clear,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  // clear beats load so a flush drops an issue fired in the same cycle
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst)               cnt <= '0;
    else if (clear)        cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - in-order issue scoreboard with RAW/WAW stall detection
// Define PIPE_SB_STATS_EN to enable the saturating stall_cnt statistic.
module pipe_scoreboard #(
  parameter int REG_CNT = pipe_sb_pkg::REG_CNT,
  parameter int REG_AW  = pipe_sb_pkg::REG_AW,
  parameter int MAX_LAT = pipe_sb_pkg::MAX_LAT,
  parameter int LAT_W   = pipe_sb_pkg::LAT_W
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_rd_we,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic              flush,
  output logic              issue_ready,
  output logic              stall_raw,
  output logic              stall_waw,
  output logic [REG_CNT-1:0] busy_vec,
  output logic [31:0]       stall_cnt
);

  import pipe_sb_pkg::*;

  logic [LAT_W-1:0]   cnt [REG_CNT];
  logic [REG_CNT-1:0] busy;
  logic               rs1_hit;
  logic               rs2_hit;
  logic               fire;
  logic               load_en;
  logic [LAT_W-1:0]   load_val;

  // register 0 is hard-wired idle, so address 0 can never hazard
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  assign rs1_hit     = (cnt[issue_rs1] != '0);
  assign rs2_hit     = (cnt[issue_rs2] != '0);
  assign stall_raw   = issue_valid && (rs1_hit || rs2_hit);
  assign stall_waw   = issue_valid && issue_rd_we && (issue_rd != '0) && (cnt[issue_rd] > issue_lat);
  assign issue_ready = !flush && !stall_raw && !stall_waw;
  assign fire        = issue_valid && issue_ready;
  assign load_en     = fire && issue_rd_we && (issue_rd != '0) && (issue_lat != '0);
  assign load_val    = LAT_W'(lat_sat(32'(issue_lat), 32'(MAX_LAT)));

  for (genvar i = 1; i < REG_CNT; i++) begin : g_entry
    sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk      (clk),
      .Rst      (Rst),
      .load     (load_en && (issue_rd == REG_AW'(i))),
      .load_val (load_val),
      .clear    (flush),
      .cnt      (cnt[i]),
      .busy     (busy[i])
    );
  end

  assign busy_vec = busy;

`ifdef PIPE_SB_STATS_EN
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst)
      stall_cnt <= '0;
    else if (issue_valid && !issue_ready && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb/tb_pipe_scoreboard.sv - directed and randomized checks against a behavioural scoreboard model
module tb_pipe_scoreboard;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs1 = '0;
  logic [4:0]  issue_rs2 = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_rd_we = 1'b0;
  logic [2:0]  issue_lat = '0;
  logic        flush = 1'b0;
  logic        issue_ready;
  logic        stall_raw;
  logic        stall_waw;
  logic [31:0] busy_vec;
  logic [31:0] stall_cnt;

  int vectors = 0;
  int errors  = 0;
  int m [32];
  longint unsigned sc_m = 0;

  logic        obs_ready, obs_raw, obs_waw;
  logic [31:0] obs_busy, obs_sc;

  pipe_scoreboard dut (
    .clk(clk), .Rst(Rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
    .issue_lat(issue_lat), .flush(flush), .issue_ready(issue_ready),
    .stall_raw(stall_raw), .stall_waw(stall_waw), .busy_vec(busy_vec),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int i = 1; i < 32; i++) b[i] = (m[i] > 0);
    return b;
  endfunction

  function automatic logic [31:0] model_sc();
`ifdef PIPE_SB_STATS_EN
    return (sc_m > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sc_m[31:0];
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m[i] = 0;
    sc_m = 0;
  endtask

  // one cycle: drive, compare against the model, then advance the model
  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic we, input logic [2:0] lat,
                      input logic fl);
    logic e_raw, e_waw, e_ready;
    @(negedge clk);
    issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
    issue_rd_we = we; issue_lat = lat; flush = fl;
    #1;
    e_raw   = v && ((rs1 != 0 && m[rs1] > 0) || (rs2 != 0 && m[rs2] > 0));
    e_waw   = v && we && rd != 0 && (m[rd] > int'(lat));
    e_ready = !fl && !e_raw && !e_waw;
    obs_ready = issue_ready; obs_raw = stall_raw; obs_waw = stall_waw;
    obs_busy = busy_vec; obs_sc = stall_cnt;
    check("stall_raw",   {31'd0, stall_raw},   {31'd0, e_raw});
    check("stall_waw",   {31'd0, stall_waw},   {31'd0, e_waw});
    check("issue_ready", {31'd0, issue_ready}, {31'd0, e_ready});
    check("busy_vec",    busy_vec,             model_busy());
    check("stall_cnt",   stall_cnt,            model_sc());
    if (v && !e_ready) sc_m++;
    for (int i = 0; i < 32; i++) if (m[i] > 0) m[i]--;
    if (fl) begin
      for (int i = 0; i < 32; i++) m[i] = 0;
    end else if (v && e_ready && we && rd != 0 && lat != 0) begin
      m[rd] = (int'(lat) > 4) ? 4 : int'(lat);
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  busy_vec, 32'd0);
    check("rst_sc",    stall_cnt, 32'd0);
    check("rst_ready", {31'd0, issue_ready}, 32'd1);
    @(negedge clk);
    Rst = 1'b0;

    // RAW: rd5 lat3 stalls a consumer while counter is 3,2,1
    step(1, 0, 0, 5, 1, 3'd3, 0);
    check("raw_issue_ready", {31'd0, obs_ready}, 32'd1);
    step(1, 5, 0, 0, 0, 3'd0, 0);
    check("raw_c3_stall", {31'd0, obs_raw}, 32'd1);
    check("raw_c3_busy", obs_busy, 32'h0000_0020);
    step(1, 5, 0, 0, 0, 3'd0, 0);
    step(1, 0, 5, 0, 0, 3'd0, 0);
    check("raw_c1_stall", {31'd0, obs_raw}, 32'd1);
    step(1, 5, 0, 0, 0, 3'd0, 0);
    check("raw_c0_ready", {31'd0, obs_ready}, 32'd1);

    // rd0 is never recorded
    step(1, 0, 0, 0, 1, 3'd4, 0);
    step(1, 0, 0, 0, 0, 3'd0, 0);
    check("rd0_ready", {31'd0, obs_ready}, 32'd1);
    check("rd0_busy", obs_busy, 32'd0);

    // WAW: rd7 lat4 then rd7 lat1 waits until counter <= 1
    step(1, 0, 0, 7, 1, 3'd4, 0);
    step(1, 0, 0, 7, 1, 3'd1, 0);
    check("waw_c4", {31'd0, obs_waw}, 32'd1);
    step(1, 0, 0, 7, 1, 3'd1, 0);
    step(1, 0, 0, 7, 1, 3'd1, 0);
    check("waw_c2", {31'd0, obs_waw}, 32'd1);
    step(1, 0, 0, 7, 1, 3'd1, 0);
    check("waw_c1_ok", {31'd0, obs_ready}, 32'd1);
    step(1, 0, 0, 7, 1, 3'd4, 0);
    check("waw_longer_ok", {31'd0, obs_waw}, 32'd0);
    repeat (5) idle();

    // flush beats a simultaneous issue
    step(1, 0, 0, 3, 1, 3'd2, 0);
    step(1, 0, 0, 4, 1, 3'd3, 1);
    check("flush_ready", {31'd0, obs_ready}, 32'd0);
    check("flush_busy_before", obs_busy, 32'h0000_0008);
    idle();
    check("flush_busy_after", obs_busy, 32'd0);

    // saturation of latency 7 to 4
    step(1, 0, 0, 9, 1, 3'd7, 0);
    step(1, 0, 0, 9, 1, 3'd3, 0);
    check("sat_waw", {31'd0, obs_waw}, 32'd1);
    repeat (5) idle();

    // build busy 0xF0, then asynchronous reset
    step(1, 0, 0, 4, 1, 3'd4, 0);
    step(1, 0, 0, 5, 1, 3'd4, 0);
    step(1, 0, 0, 6, 1, 3'd4, 0);
    step(1, 0, 0, 7, 1, 3'd4, 0);
    idle();
    check("pre_rst_busy", obs_busy, 32'h0000_00F0);
    #2;
    Rst = 1'b1;
    #1;
    check("async_rst_busy", busy_vec, 32'd0);
    check("async_rst_sc", stall_cnt, 32'd0);
    model_clear();
    @(negedge clk);
    Rst = 1'b0;

    // five stalled cycles: four RAW plus one flush-blocked issue
    step(1, 0, 0, 9, 1, 3'd4, 0);
    repeat (4) step(1, 9, 0, 0, 0, 3'd0, 0);
    step(1, 0, 0, 0, 0, 3'd0, 1);
    idle();
`ifdef PIPE_SB_STATS_EN
    check("stats_five", obs_sc, 32'd5);
`else
    check("stats_off", obs_sc, 32'd0);
`endif

    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) < 8),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
